pc_sequencer: RTL and testbench

Fetch-stage controller that sequences the Program Counter state element in the pipeline processor. Each cycle it selects the next PC value, drives the PC write enable and issues IF/ID flushes. It follows a fixed priority among exception entry, ERET, taken branch, jump, hazard stall and sequential fetch. It also holds a pending redirect across instruction-memory wait states and keeps the EPC register.

---
 rtl/pc_seq_pkg.sv | 28 ++
 rtl/pc_sequencer_next_pc_sel.sv | 51 +++++
 rtl/pc_sequencer.sv | 150 +++++++++++++++
 tb/tb_pc_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;

    // Sequencer FSM encoding.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Which event (if any) is redirecting the fetch stream this cycle.
    typedef enum logic [2:0] {
        NONE = 3'd0,
        EXC  = 3'd1,
        ERET = 3'd2,
        BR   = 3'd3,
        JMP  = 3'd4
    } redir_src_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_4180;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// Combinational redirect priority encoder: exc > eret > branch > jump > sequential.
module next_pc_sel
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        exc_req,
    input  logic        eret,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic [31:0] epc,
    input  logic [31:0] pc_cur,
    output logic [31:0] target,
    output redir_src_t  src,
    output logic        if_flush,
    output logic        id_flush
);

    // Pick the highest-priority redirect; fall through to pc + 4.
    always_comb begin
        // NOTE: every output gets a default before the priority chain so no path leaves one unassigned (which would infer a latch).
        target   = pc_cur + 32'd4;
        src      = NONE;
        if_flush = 1'b0;
        id_flush = 1'b0;
        if (exc_req) begin
            target   = EXC_VECTOR;
            src      = EXC;
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (eret) begin
            target   = epc;
            src      = ERET;
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (br_taken) begin
            target   = br_target;
            src      = BR;
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (jump_valid) begin
            // A jump resolves in ID, so only the instruction behind it in IF is wrong.
            target   = jump_target;
            src      = JMP;
            if_flush = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: next-PC selection, PC write enable, flushes,
// pending redirect across instruction-memory wait states, and the EPC register.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        eret,
    output logic [31:0] new_PC,
    output logic        PC_IFWrite,
    output logic        if_flush,
    output logic        id_flush,
    output logic        imem_req,
    output logic        fetch_valid,
    output logic [31:0] epc
);

    state_t      state, state_next;
    logic        pend_valid, pend_valid_next;
    logic [31:0] pend_target, pend_target_next;
    logic [31:0] epc_next;
    logic [31:0] new_pc_raw;

    logic [31:0] sel_target;
    redir_src_t  sel_src;
    logic        sel_if_flush;
    logic        sel_id_flush;
    logic        redirect;
    logic        wait_replace;

    next_pc_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_sel (
        .exc_req     (exc_req),
        .eret        (eret),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .epc         (epc),
        .pc_cur      (pc_cur),
        .target      (sel_target),
        .src         (sel_src),
        .if_flush    (sel_if_flush),
        .id_flush    (sel_id_flush)
    );

    assign redirect     = (sel_src != NONE);
    // While waiting, ID holds a bubble, so only MEM/EX events may replace the pending target.
    assign wait_replace = (sel_src == EXC) || (sel_src == ERET) || (sel_src == BR);
    assign new_PC       = word_align(new_pc_raw);

    // Next-state and output decode for the BOOT/RUN/WAIT sequencer.
    always_comb begin
        state_next       = state;
        pend_valid_next  = pend_valid;
        pend_target_next = pend_target;
        epc_next         = epc;
        new_pc_raw       = RESET_VECTOR;
        PC_IFWrite       = 1'b0;
        if_flush         = 1'b0;
        id_flush         = 1'b0;
        imem_req         = 1'b0;
        fetch_valid      = 1'b0;

        case (state)
            BOOT: begin
                new_pc_raw = RESET_VECTOR;
                PC_IFWrite = 1'b1;
                if_flush   = 1'b1;
                state_next = RUN;
            end

            RUN: begin
                imem_req   = 1'b1;
                new_pc_raw = sel_target;
                if_flush   = sel_if_flush;
                id_flush   = sel_id_flush;
                if (sel_src == EXC) begin
                    epc_next = exc_pc;
                end
                if (imem_ready) begin
                    // A redirect outranks the hazard stall and always writes the PC.
                    PC_IFWrite  = redirect || !stall;
                    fetch_valid = !redirect && !stall;
                end else if (redirect) begin
                    pend_valid_next  = 1'b1;
                    pend_target_next = word_align(sel_target);
                    state_next       = WAIT;
                end
            end

            WAIT: begin
                imem_req   = 1'b1;
                if_flush   = 1'b1;
                PC_IFWrite = imem_ready;
                new_pc_raw = pend_target;
                if (wait_replace) begin
                    new_pc_raw = sel_target;
                    id_flush   = 1'b1;
                    if (sel_src == EXC) begin
                        epc_next = exc_pc;
                    end
                end
                if (imem_ready) begin
                    pend_valid_next = 1'b0;
                    state_next      = RUN;
                end else begin
                    pend_target_next = word_align(new_pc_raw);
                end
            end

            default: begin
                new_pc_raw = RESET_VECTOR;
                PC_IFWrite = 1'b1;
                if_flush   = 1'b1;
                state_next = BOOT;
            end
        endcase
    end

    // State, pending redirect and EPC registers; reset drops any pending redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            epc         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values together.
            state       <= state_next;
            pend_valid  <= pend_valid_next;
            pend_target <= pend_target_next;
            epc         <= epc_next;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer, with a simple PC register model.
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] pc_cur;
    logic        imem_ready;
    logic        stall;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_req;
    logic [31:0] exc_pc;
    logic        eret;
    logic [31:0] new_PC;
    logic        PC_IFWrite;
    logic        if_flush;
    logic        id_flush;
    logic        imem_req;
    logic        fetch_valid;
    logic [31:0] epc;

    logic [31:0] pc_reg;
    logic        pc_ovr_en;
    logic [31:0] pc_ovr;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .pc_cur      (pc_cur),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .exc_req     (exc_req),
        .exc_pc      (exc_pc),
        .eret        (eret),
        .new_PC      (new_PC),
        .PC_IFWrite  (PC_IFWrite),
        .if_flush    (if_flush),
        .id_flush    (id_flush),
        .imem_req    (imem_req),
        .fetch_valid (fetch_valid),
        .epc         (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register driven by the sequencer's write enable.
    always @(posedge clk or posedge rst) begin
        if (rst) pc_reg <= '0;
        else if (PC_IFWrite) pc_reg <= new_PC;
    end

    assign pc_cur = pc_ovr_en ? pc_ovr : pc_reg;

    task automatic clear_inputs();
        imem_ready  = 1'b1;
        stall       = 1'b0;
        jump_valid  = 1'b0;
        jump_target = '0;
        br_taken    = 1'b0;
        br_target   = '0;
        exc_req     = 1'b0;
        exc_pc      = '0;
        eret        = 1'b0;
    endtask

    // Move to the next negative edge with all requests idle.
    task automatic next_cycle();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pc_ovr_en = 1'b0;
        pc_ovr = '0;
        clear_inputs();
        #2;
        checks++; if (new_PC !== 32'h0000_3000) begin errors++; $display("FAIL rst_new_pc got %h exp %h", new_PC, 32'h0000_3000); end
        checks++; if (PC_IFWrite !== 1'b1) begin errors++; $display("FAIL rst_pcwrite got %b exp 1", PC_IFWrite); end
        checks++; if (if_flush !== 1'b1 || id_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got if=%b id=%b exp if=1 id=0", if_flush, id_flush); end
        checks++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_req got req=%b fv=%b exp 0 0", imem_req, fetch_valid); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rst_epc got %h exp 0", epc); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (new_PC !== 32'h0000_3000 || PC_IFWrite !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_cycle got pc=%h we=%b fv=%b exp 3000 1 0", new_PC, PC_IFWrite, fetch_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4] = '{32'h3004, 32'h3008, 32'h300C, 32'h3010};
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1;
            checks++; if (new_PC !== exp_pc[i]) begin errors++; $display("FAIL seq%0d new_pc got %h exp %h", i, new_PC, exp_pc[i]); end
            checks++; if (fetch_valid !== 1'b1 || PC_IFWrite !== 1'b1 || if_flush !== 1'b0 || id_flush !== 1'b0 || imem_req !== 1'b1) begin
                errors++; $display("FAIL seq%0d ctrl got fv=%b we=%b if=%b id=%b req=%b exp 1 1 0 0 1", i, fetch_valid, PC_IFWrite, if_flush, id_flush, imem_req);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            stall = 1'b1;
            #1;
            checks++; if (PC_IFWrite !== 1'b0 || fetch_valid !== 1'b0 || if_flush !== 1'b0 || id_flush !== 1'b0) begin
                errors++; $display("FAIL stall%0d got we=%b fv=%b if=%b id=%b exp 0 0 0 0", i, PC_IFWrite, fetch_valid, if_flush, id_flush);
            end
        end
        next_cycle();
        #1;
        checks++; if (new_PC !== 32'h3014 || PC_IFWrite !== 1'b1 || fetch_valid !== 1'b1) begin errors++; $display("FAIL stall_release got pc=%h we=%b fv=%b exp 3014 1 1", new_PC, PC_IFWrite, fetch_valid); end
    endtask

    task automatic test_priority();
        next_cycle();
        br_taken = 1'b1; br_target = 32'h3100;
        jump_valid = 1'b1; jump_target = 32'h3200;
        #1;
        checks++; if (new_PC !== 32'h3100) begin errors++; $display("FAIL br_over_jmp new_pc got %h exp %h", new_PC, 32'h3100); end
        checks++; if (if_flush !== 1'b1 || id_flush !== 1'b1 || PC_IFWrite !== 1'b1 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL br_ctrl got if=%b id=%b we=%b fv=%b exp 1 1 1 0", if_flush, id_flush, PC_IFWrite, fetch_valid);
        end
    endtask

    task automatic test_wait_jump();
        next_cycle();
        jump_valid = 1'b1; jump_target = 32'h3200; imem_ready = 1'b0;
        #1;
        checks++; if (new_PC !== 32'h3200 || PC_IFWrite !== 1'b0 || if_flush !== 1'b1 || id_flush !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL jmp_wait0 got pc=%h we=%b if=%b id=%b fv=%b exp 3200 0 1 0 0", new_PC, PC_IFWrite, if_flush, id_flush, fetch_valid);
        end
        for (int i = 1; i < 3; i++) begin
            next_cycle();
            imem_ready = 1'b0;
            // Jumps are ignored while waiting.
            jump_valid = 1'b1; jump_target = 32'h3300;
            #1;
            checks++; if (new_PC !== 32'h3200 || PC_IFWrite !== 1'b0 || if_flush !== 1'b1 || id_flush !== 1'b0 || imem_req !== 1'b1) begin
                errors++; $display("FAIL jmp_wait%0d got pc=%h we=%b if=%b id=%b req=%b exp 3200 0 1 0 1", i, new_PC, PC_IFWrite, if_flush, id_flush, imem_req);
            end
        end
        next_cycle();
        #1;
        checks++; if (new_PC !== 32'h3200 || PC_IFWrite !== 1'b1 || fetch_valid !== 1'b0 || if_flush !== 1'b1) begin
            errors++; $display("FAIL jmp_write got pc=%h we=%b fv=%b if=%b exp 3200 1 0 1", new_PC, PC_IFWrite, fetch_valid, if_flush);
        end
        next_cycle();
        #1;
        checks++; if (new_PC !== 32'h3204 || fetch_valid !== 1'b1 || if_flush !== 1'b0) begin errors++; $display("FAIL jmp_resume got pc=%h fv=%b if=%b exp 3204 1 0", new_PC, fetch_valid, if_flush); end
    endtask

    task automatic test_exc_in_wait();
        next_cycle();
        jump_valid = 1'b1; jump_target = 32'h3200; imem_ready = 1'b0;
        next_cycle();
        imem_ready = 1'b0; exc_req = 1'b1; exc_pc = 32'h3020;
        #1;
        checks++; if (id_flush !== 1'b1 || if_flush !== 1'b1 || PC_IFWrite !== 1'b0) begin errors++; $display("FAIL exc_wait_ctrl got id=%b if=%b we=%b exp 1 1 0", id_flush, if_flush, PC_IFWrite); end
        next_cycle();
        imem_ready = 1'b0;
        #1;
        checks++; if (new_PC !== 32'h4180 || PC_IFWrite !== 1'b0) begin errors++; $display("FAIL exc_wait_pend got pc=%h we=%b exp 4180 0", new_PC, PC_IFWrite); end
        checks++; if (epc !== 32'h3020) begin errors++; $display("FAIL exc_wait_epc got %h exp %h", epc, 32'h3020); end
        next_cycle();
        #1;
        checks++; if (new_PC !== 32'h4180 || PC_IFWrite !== 1'b1) begin errors++; $display("FAIL exc_wait_write got pc=%h we=%b exp 4180 1", new_PC, PC_IFWrite); end
        next_cycle();
        eret = 1'b1;
        #1;
        checks++; if (new_PC !== 32'h3020 || if_flush !== 1'b1 || id_flush !== 1'b1 || PC_IFWrite !== 1'b1) begin
            errors++; $display("FAIL eret got pc=%h if=%b id=%b we=%b exp 3020 1 1 1", new_PC, if_flush, id_flush, PC_IFWrite);
        end
    endtask

    task automatic test_exc_eret_same();
        next_cycle();
        exc_req = 1'b1; exc_pc = 32'h3024; eret = 1'b1;
        #1;
        checks++; if (new_PC !== 32'h4180 || id_flush !== 1'b1) begin errors++; $display("FAIL exc_eret got pc=%h id=%b exp 4180 1", new_PC, id_flush); end
        next_cycle();
        #1;
        checks++; if (epc !== 32'h3024) begin errors++; $display("FAIL exc_eret_epc got %h exp %h", epc, 32'h3024); end
        checks++; if (new_PC !== 32'h4184 || fetch_valid !== 1'b1) begin errors++; $display("FAIL exc_entry_seq got pc=%h fv=%b exp 4184 1", new_PC, fetch_valid); end
    endtask

    task automatic test_boundaries();
        next_cycle();
        pc_ovr_en = 1'b1; pc_ovr = 32'hFFFF_FFFC;
        #1;
        checks++; if (new_PC !== 32'h0000_0000) begin errors++; $display("FAIL wrap got %h exp %h", new_PC, 32'h0); end
        pc_ovr_en = 1'b0;
        next_cycle();
        jump_valid = 1'b1; jump_target = 32'h3203;
        #1;
        checks++; if (new_PC !== 32'h3200 || if_flush !== 1'b1 || id_flush !== 1'b0) begin errors++; $display("FAIL align got pc=%h if=%b id=%b exp 3200 1 0", new_PC, if_flush, id_flush); end
    endtask

    task automatic test_reset_mid_wait();
        next_cycle();
        jump_valid = 1'b1; jump_target = 32'h3400; imem_ready = 1'b0;
        next_cycle();
        imem_ready = 1'b0;
        #1;
        checks++; if (new_PC !== 32'h3400 || imem_req !== 1'b1) begin errors++; $display("FAIL pre_rst_wait got pc=%h req=%b exp 3400 1", new_PC, imem_req); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (new_PC !== 32'h3000 || imem_req !== 1'b0 || PC_IFWrite !== 1'b1 || if_flush !== 1'b1 || id_flush !== 1'b0 || epc !== 32'h0) begin
            errors++; $display("FAIL mid_rst got pc=%h req=%b we=%b if=%b id=%b epc=%h exp 3000 0 1 1 0 0", new_PC, imem_req, PC_IFWrite, if_flush, id_flush, epc);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++; if (new_PC !== 32'h3000 || fetch_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL post_rst_boot got pc=%h fv=%b req=%b exp 3000 0 0", new_PC, fetch_valid, imem_req); end
        next_cycle();
        #1;
        checks++; if (new_PC !== 32'h3004 || fetch_valid !== 1'b1 || if_flush !== 1'b0) begin errors++; $display("FAIL post_rst_run got pc=%h fv=%b if=%b exp 3004 1 0", new_PC, fetch_valid, if_flush); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_priority();
        test_wait_jump();
        test_exc_in_wait();
        test_exc_eret_same();
        test_boundaries();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
